// File: rtl/rcn_uart.sv
// ---------------------------------------------------------------------------
// rcn_uart
//   UART responder on the 69-bit RCN ring: 8 data bits, 1 stop bit, with a
//   TX FIFO and an RX FIFO. Requests that decode to this block are answered
//   in the same slot. Every other slot is forwarded unchanged.
//
//   Ring word: {valid, pending, wr, id[5:0], mask[3:0], addr[23:2], seq[1:0],
//   data[31:0]}.
//
//   Register map (addr[3:2]):
//     0 DATA   : write pushes data[7:0] into TX FIFO (mask[0]).
//                Read returns {rx_valid, rx_byte} and pops RX FIFO.
//     1 STATUS : {tx_idle, par_err, frm_err, ovr, rx_full, rx_empty, tx_full}
//     2 BAUD   : bit period minus one, in clocks. Used from the next frame start.
//     3 CLEAR  : 1s in data[7:5] clear par_err / frm_err / ovr.
//
//   Optional feature macro: RCN_UART_PARITY_EN
//     Adds one even-parity bit after the data bits in both directions.
//     An RX parity mismatch sets par_err, and the byte is still stored.
//
// Ports
//   clk      in   ring / system clock
//   rst      in   asynchronous active-high reset
//   rcn_in   in   69-bit ring input
//   rcn_out  out  69-bit ring output, registered
//   uart_rx  in   serial input, asynchronous to clk
//   uart_tx  out  serial output, idle high
// ---------------------------------------------------------------------------
module rcn_uart #(
    parameter logic [23:0] ADDR_BASE      = 24'hFFFFE0,
    parameter int          FIFO_DEPTH_LG2 = 4,
    parameter logic [15:0] BAUD_DIV_RST   = 16'd433
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [68:0] rcn_in,
    output logic [68:0] rcn_out,
    input  logic        uart_rx,
    output logic        uart_tx
);

    localparam int              DEPTH = 1 << FIFO_DEPTH_LG2;
    localparam int              PW    = FIFO_DEPTH_LG2 + 1;
    localparam logic [PW-1:0]   P_ONE = {{(PW-1){1'b0}}, 1'b1};

    // ---------------- ring decode ----------------
    logic        req_hit, req_wr;
    logic [3:0]  req_mask;
    logic [1:0]  req_reg;
    logic [31:0] req_data;
    logic [31:0] rd_data;

    assign req_hit  = rcn_in[68] & rcn_in[67] & (rcn_in[55:36] == ADDR_BASE[23:4]);
    assign req_wr   = rcn_in[66];
    assign req_mask = rcn_in[59:56];
    assign req_reg  = rcn_in[35:34];
    assign req_data = rcn_in[31:0];

    logic tx_push, rx_pop_req, baud_wr, clr_wr;
    assign tx_push    = req_hit &  req_wr & (req_reg == 2'd0) & req_mask[0];
    assign rx_pop_req = req_hit & ~req_wr & (req_reg == 2'd0);
    assign baud_wr    = req_hit &  req_wr & (req_reg == 2'd2);
    assign clr_wr     = req_hit &  req_wr & (req_reg == 2'd3) & req_mask[0];

    // ---------------- registers / flags ----------------
    logic [15:0] baud;
    logic        ovr, frm_err, par_err;
    logic        tx_idle;

    // ---------------- TX FIFO ----------------
    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wr, tx_rd;
    logic          tx_empty, tx_full, tx_load, tx_wr_en;
    logic [7:0]    tx_head;

    assign tx_empty = (tx_wr == tx_rd);
    assign tx_full  = (tx_wr[PW-1] != tx_rd[PW-1]) && (tx_wr[PW-2:0] == tx_rd[PW-2:0]);
    assign tx_head  = tx_mem[tx_rd[PW-2:0]];
    // A push into a full FIFO is accepted when the shifter pops the same cycle.
    assign tx_wr_en = tx_push & (~tx_full | tx_load);

    always_ff @(posedge clk) begin
        if (tx_wr_en) tx_mem[tx_wr[PW-2:0]] <= req_data[7:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_wr <= '0;
            tx_rd <= '0;
        end else begin
            if (tx_wr_en) tx_wr <= tx_wr + P_ONE;
            if (tx_load)  tx_rd <= tx_rd + P_ONE;
        end
    end

    // ---------------- RX FIFO ----------------
    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wr, rx_rd;
    logic          rx_empty, rx_full, rx_pop, rx_good, rx_wr_en, ovr_set;
    logic [7:0]    rx_sh, rx_sh_n;

    assign rx_empty = (rx_wr == rx_rd);
    assign rx_full  = (rx_wr[PW-1] != rx_rd[PW-1]) && (rx_wr[PW-2:0] == rx_rd[PW-2:0]);
    assign rx_pop   = rx_pop_req & ~rx_empty;
    assign rx_wr_en = rx_good & (~rx_full | rx_pop);
    assign ovr_set  = rx_good & ~rx_wr_en;

    always_ff @(posedge clk) begin
        if (rx_wr_en) rx_mem[rx_wr[PW-2:0]] <= rx_sh;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_wr <= '0;
            rx_rd <= '0;
        end else begin
            if (rx_wr_en) rx_wr <= rx_wr + P_ONE;
            if (rx_pop)   rx_rd <= rx_rd + P_ONE;
        end
    end

    // ---------------- TX state machine ----------------
    typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PAR, TX_STOP} tx_state_t;
    tx_state_t   tx_state, tx_state_n;
    logic [15:0] tx_cnt, tx_cnt_n, tx_baud, tx_baud_n;
    logic [2:0]  tx_bit, tx_bit_n;
    logic [7:0]  tx_sh, tx_sh_n;
`ifdef RCN_UART_PARITY_EN
    logic        tx_par, tx_par_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_state <= TX_IDLE;
            tx_cnt   <= '0;
            tx_baud  <= '0;
            tx_bit   <= '0;
            tx_sh    <= '0;
`ifdef RCN_UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else begin
            tx_state <= tx_state_n;
            tx_cnt   <= tx_cnt_n;
            tx_baud  <= tx_baud_n;
            tx_bit   <= tx_bit_n;
            tx_sh    <= tx_sh_n;
`ifdef RCN_UART_PARITY_EN
            tx_par   <= tx_par_n;
`endif
        end
    end

    always_comb begin
        tx_state_n = tx_state;
        tx_cnt_n   = tx_cnt;
        tx_baud_n  = tx_baud;
        tx_bit_n   = tx_bit;
        tx_sh_n    = tx_sh;
        tx_load    = 1'b0;
`ifdef RCN_UART_PARITY_EN
        tx_par_n   = tx_par;
`endif
        if (tx_state != TX_IDLE && tx_cnt != 16'd0) begin
            tx_cnt_n = tx_cnt - 16'd1;
        end else begin
            case (tx_state)
                TX_IDLE:  tx_load = ~tx_empty;
                TX_START: begin
                    tx_state_n = TX_DATA;
                    tx_cnt_n   = tx_baud;
                    tx_bit_n   = 3'd0;
                end
                TX_DATA: begin
                    tx_cnt_n = tx_baud;
                    tx_sh_n  = {1'b0, tx_sh[7:1]};
                    tx_bit_n = tx_bit + 3'd1;
                    if (tx_bit == 3'd7) begin
`ifdef RCN_UART_PARITY_EN
                        tx_state_n = TX_PAR;
`else
                        tx_state_n = TX_STOP;
`endif
                    end
                end
`ifdef RCN_UART_PARITY_EN
                TX_PAR: begin
                    tx_state_n = TX_STOP;
                    tx_cnt_n   = tx_baud;
                end
`endif
                TX_STOP: begin
                    // Chain straight into the next start bit when data waits.
                    tx_state_n = TX_IDLE;
                    tx_load    = ~tx_empty;
                end
                default: tx_state_n = TX_IDLE;
            endcase
            if (tx_load) begin
                tx_state_n = TX_START;
                tx_cnt_n   = baud;
                tx_baud_n  = baud;
                tx_sh_n    = tx_head;
`ifdef RCN_UART_PARITY_EN
                tx_par_n   = ^tx_head;
`endif
            end
        end
    end

    always_comb begin
        uart_tx = 1'b1;
        case (tx_state)
            TX_START: uart_tx = 1'b0;
            TX_DATA:  uart_tx = tx_sh[0];
`ifdef RCN_UART_PARITY_EN
            TX_PAR:   uart_tx = tx_par;
`endif
            default:  uart_tx = 1'b1;
        endcase
    end

    assign tx_idle = tx_empty & (tx_state == TX_IDLE);

    // ---------------- RX synchroniser + state machine ----------------
    logic rx_s1, rx_s2, rx_prev;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_s1   <= uart_rx;
            rx_s2   <= rx_s1;
            rx_prev <= rx_s2;
        end
    end

    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP} rx_state_t;
    rx_state_t   rx_state, rx_state_n;
    logic [15:0] rx_cnt, rx_cnt_n, rx_baud, rx_baud_n;
    logic [2:0]  rx_bit, rx_bit_n;
    logic        rx_frm;
`ifdef RCN_UART_PARITY_EN
    logic        rx_pbit, rx_pbit_n;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_baud  <= '0;
            rx_bit   <= '0;
            rx_sh    <= '0;
`ifdef RCN_UART_PARITY_EN
            rx_pbit  <= 1'b0;
`endif
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_baud  <= rx_baud_n;
            rx_bit   <= rx_bit_n;
            rx_sh    <= rx_sh_n;
`ifdef RCN_UART_PARITY_EN
            rx_pbit  <= rx_pbit_n;
`endif
        end
    end

    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt;
        rx_baud_n  = rx_baud;
        rx_bit_n   = rx_bit;
        rx_sh_n    = rx_sh;
        rx_good    = 1'b0;
        rx_frm     = 1'b0;
`ifdef RCN_UART_PARITY_EN
        rx_pbit_n  = rx_pbit;
`endif
        if (rx_state == RX_IDLE) begin
            if (rx_prev & ~rx_s2) begin
                // First sample lands half a bit into the start bit.
                rx_state_n = RX_START;
                rx_cnt_n   = baud >> 1;
                rx_baud_n  = baud;
            end
        end else if (rx_cnt != 16'd0) begin
            rx_cnt_n = rx_cnt - 16'd1;
        end else begin
            rx_cnt_n = rx_baud;
            case (rx_state)
                RX_START: begin
                    rx_bit_n   = 3'd0;
                    rx_state_n = rx_s2 ? RX_IDLE : RX_DATA;
                end
                RX_DATA: begin
                    rx_sh_n  = {rx_s2, rx_sh[7:1]};
                    rx_bit_n = rx_bit + 3'd1;
                    if (rx_bit == 3'd7) begin
`ifdef RCN_UART_PARITY_EN
                        rx_state_n = RX_PAR;
`else
                        rx_state_n = RX_STOP;
`endif
                    end
                end
`ifdef RCN_UART_PARITY_EN
                RX_PAR: begin
                    rx_pbit_n  = rx_s2;
                    rx_state_n = RX_STOP;
                end
`endif
                RX_STOP: begin
                    rx_state_n = RX_IDLE;
                    rx_good    = rx_s2;
                    rx_frm     = ~rx_s2;
                end
                default: rx_state_n = RX_IDLE;
            endcase
        end
    end

    // ---------------- CSRs and sticky flags ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            baud    <= BAUD_DIV_RST;
            ovr     <= 1'b0;
            frm_err <= 1'b0;
        end else begin
            if (baud_wr && req_mask[0]) baud[7:0]  <= req_data[7:0];
            if (baud_wr && req_mask[1]) baud[15:8] <= req_data[15:8];
            ovr     <= ovr_set | (ovr     & ~(clr_wr & req_data[5]));
            frm_err <= rx_frm  | (frm_err & ~(clr_wr & req_data[6]));
        end
    end

`ifdef RCN_UART_PARITY_EN
    logic rx_perr;
    assign rx_perr = rx_good & (rx_pbit != ^rx_sh);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) par_err <= 1'b0;
        else     par_err <= rx_perr | (par_err & ~(clr_wr & req_data[7]));
    end
`else
    assign par_err = 1'b0;
`endif

    // ---------------- read mux and ring output ----------------
    always_comb begin
        rd_data = 32'd0;
        case (req_reg)
            2'd0: rd_data = {23'd0, ~rx_empty, rx_empty ? 8'h00 : rx_mem[rx_rd[PW-2:0]]};
            2'd1: rd_data = {25'd0, tx_idle, par_err, frm_err, ovr, rx_full, rx_empty, tx_full};
            2'd2: rd_data = {16'd0, baud};
            default: rd_data = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)          rcn_out <= '0;
        else if (req_hit) rcn_out <= {rcn_in[68], 1'b0, rcn_in[66:32], req_wr ? req_data : rd_data};
        else              rcn_out <= rcn_in;
    end

endmodule

// File: tb/tb_rcn_uart.sv
module tb_rcn_uart;

    localparam logic [23:0] BASE = 24'hFFFFE0;
`ifdef RCN_UART_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [68:0] rcn_in, rcn_out;
    logic        uart_tx, uart_rx, rx_drv, loop_en;
    int          total = 0, bad = 0, cyc = 0;

    assign uart_rx = loop_en ? uart_tx : rx_drv;

    rcn_uart dut (
        .clk     (clk),
        .rst     (rst),
        .rcn_in  (rcn_in),
        .rcn_out (rcn_out),
        .uart_rx (uart_rx),
        .uart_tx (uart_tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #3_000_000;
        $display("FAIL watchdog: no finish within time limit");
        $fatal(1);
    end

    // Reference model state
    logic [7:0] exp_q[$];
    bit         m_ovr, m_frm, m_par;
    int         m_baud;

    task automatic chk(input string tag, input logic [68:0] got, input logic [68:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] exp_status(input bit idle, input bit txf);
        exp_status = {25'd0, idle, m_par, m_frm, m_ovr,
                      exp_q.size() == 16, exp_q.size() == 0, txf};
    endfunction

    // One ring request to this block; checks the returned slot header.
    task automatic ring(input bit wr, input logic [3:0] mask, input logic [1:0] ri,
                        input logic [31:0] wd, output logic [31:0] rd);
        logic [5:0]  id;
        logic [1:0]  seq;
        logic [21:0] a;
        id  = 6'($urandom);
        seq = 2'($urandom);
        a   = {BASE[23:4], ri};
        @(negedge clk);
        rcn_in = {1'b1, 1'b1, wr, id, mask, a, seq, wd};
        @(posedge clk);
        #1;
        rd = rcn_out[31:0];
        chk("ring_hdr", {rcn_out[68:32], 32'd0}, {1'b1, 1'b0, wr, id, mask, a, seq, 32'd0});
        if (wr) chk("wr_echo", {37'd0, rcn_out[31:0]}, {37'd0, wd});
        @(negedge clk);
        rcn_in = '0;
    endtask

    task automatic rd_reg(input logic [1:0] ri, output logic [31:0] v);
        ring(1'b0, 4'hF, ri, $urandom, v);
    endtask

    task automatic wr_reg(input logic [1:0] ri, input logic [3:0] mask, input logic [31:0] v);
        logic [31:0] dummy;
        ring(1'b1, mask, ri, v, dummy);
    endtask

    task automatic chk_status(input string tag, input bit idle, input bit txf);
        logic [31:0] v;
        rd_reg(2'd1, v);
        chk(tag, {37'd0, v}, {37'd0, exp_status(idle, txf)});
    endtask

    task automatic chk_data_read(input string tag);
        logic [31:0] v, e;
        if (exp_q.size() == 0) e = 32'd0;
        else                   e = {23'd0, 1'b1, exp_q.pop_front()};
        rd_reg(2'd0, v);
        chk(tag, {37'd0, v}, {37'd0, e});
    endtask

    // Serial frame into uart_rx; model updated from the frame rules.
    task automatic send_serial(input logic [7:0] b, input bit stop_ok, input bit par_ok);
        int bc;
        bc = m_baud + 1;
        @(negedge clk);
        rx_drv = 1'b0;
        repeat (bc) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_drv = b[i];
            repeat (bc) @(negedge clk);
        end
`ifdef RCN_UART_PARITY_EN
        rx_drv = (^b) ^ ~par_ok;
        repeat (bc) @(negedge clk);
`endif
        rx_drv = stop_ok;
        repeat (bc) @(negedge clk);
        rx_drv = 1'b1;
        repeat (2 * bc) @(negedge clk);
        if (!stop_ok) m_frm = 1'b1;
        else begin
`ifdef RCN_UART_PARITY_EN
            if (!par_ok) m_par = 1'b1;
`endif
            if (exp_q.size() < 16) exp_q.push_back(b);
            else                   m_ovr = 1'b1;
        end
    endtask

    // Waits for a start bit, then checks every clock of the whole frame.
    task automatic tx_frame_check(input logic [7:0] b);
        logic fb [NBITS];
        int   n, bc;
        bc = m_baud + 1;
        fb[0] = 1'b0;
        for (int i = 0; i < 8; i++) fb[i+1] = b[i];
`ifdef RCN_UART_PARITY_EN
        fb[9] = ^b;
`endif
        fb[NBITS-1] = 1'b1;
        n = 0;
        while (uart_tx !== 1'b0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("tx_start_seen", {68'd0, n < 200}, 69'd1);
        for (int k = 0; k < NBITS * bc; k++) begin
            if (k > 0) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("tx_bit%0d", k / bc), {68'd0, uart_tx}, {68'd0, fb[k / bc]});
        end
        @(posedge clk);
        #1;
        chk("tx_idle_line", {68'd0, uart_tx}, 69'd1);
    endtask

    initial begin
        logic [31:0] v;
        logic [7:0]  b;
        logic [68:0] w;
        int          kind, t0;

        rst = 1'b1; rcn_in = '0; rx_drv = 1'b1; loop_en = 1'b0;
        m_baud = 433; m_ovr = 0; m_frm = 0; m_par = 0;

        // Reset state, with ring traffic present during reset
        repeat (2) @(negedge clk);
        rcn_in = {5'($urandom), $urandom, $urandom};
        @(posedge clk);
        #1;
        chk("rst_rcn_out", rcn_out, 69'd0);
        chk("rst_uart_tx", {68'd0, uart_tx}, 69'd1);
        @(negedge clk);
        rst = 1'b0; rcn_in = '0;

        chk_status("status_rst", 1'b1, 1'b0);
        rd_reg(2'd2, v);
        chk("baud_rst", {37'd0, v}, {37'd0, 32'd433});
        rd_reg(2'd3, v);
        chk("clear_reads_0", {37'd0, v}, 69'd0);

        // BAUD byte masks: only low byte written, then full write
        wr_reg(2'd2, 4'h1, 32'hFFFF_FF04);
        rd_reg(2'd2, v);
        chk("baud_mask_lo", {37'd0, v}, {37'd0, 32'h0000_0104});
        wr_reg(2'd2, 4'h3, 32'h0000_0004);
        m_baud = 4;
        rd_reg(2'd2, v);
        chk("baud_4", {37'd0, v}, {37'd0, 32'd4});

        // TX waveform
        wr_reg(2'd0, 4'hF, 32'h0000_00A5);
        tx_frame_check(8'hA5);
        for (int i = 0; i < 2; i++) begin
            b = 8'($urandom);
            wr_reg(2'd0, 4'hF, {24'd0, b});
            tx_frame_check(b);
        end
        // mask[0]=0 write to DATA must not push
        wr_reg(2'd0, 4'hE, 32'h0000_0055);
        repeat (3) @(posedge clk);
        chk_status("status_after_tx", 1'b1, 1'b0);

        // Loopback
        loop_en = 1'b1;
        wr_reg(2'd0, 4'hF, 32'h0000_003C);
        exp_q.push_back(8'h3C);
        repeat (NBITS * 5 + 20) @(posedge clk);
        chk_data_read("loop_3c");
        chk_data_read("loop_empty");
        for (int i = 0; i < 3; i++) begin
            b = 8'($urandom);
            wr_reg(2'd0, 4'hF, {24'd0, b});
            exp_q.push_back(b);
        end
        repeat (3 * NBITS * 5 + 20) @(posedge clk);
        chk_status("status_loop3", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) chk_data_read("loop_burst");
        loop_en = 1'b0;

        // Pass-through slots
        for (int i = 0; i < 24; i++) begin
            w    = {5'($urandom), $urandom, $urandom};
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                w[68] = 1'b1; w[67] = 1'b1;
                if (w[55:36] == BASE[23:4]) w[40] = ~w[40];
            end else if (kind == 1) begin
                w[68] = 1'b1; w[67] = 1'b0;
                if ($urandom_range(0, 1) == 1) w[55:36] = BASE[23:4];
            end else begin
                w[68] = 1'b0;
            end
            @(negedge clk);
            rcn_in = w;
            @(posedge clk);
            #1;
            chk("pass_through", rcn_out, w);
        end
        @(negedge clk);
        rcn_in = '0;
        chk_status("status_after_pass", 1'b1, 1'b0);

        // RX overflow: 17 bytes, no reads
        for (int i = 0; i < 17; i++) send_serial(8'($urandom), 1'b1, 1'b1);
        chk_status("status_ovr", 1'b1, 1'b0);
        for (int i = 0; i < 17; i++) chk_data_read("ovr_readback");
        wr_reg(2'd3, 4'hF, 32'h0000_0020);
        m_ovr = 1'b0;
        chk_status("status_ovr_clr", 1'b1, 1'b0);

        // Framing error
        send_serial(8'($urandom), 1'b0, 1'b1);
        chk_status("status_frm", 1'b1, 1'b0);
        chk_data_read("frm_empty");
        wr_reg(2'd3, 4'hF, 32'h0000_0040);
        m_frm = 1'b0;
        chk_status("status_frm_clr", 1'b1, 1'b0);

`ifdef RCN_UART_PARITY_EN
        send_serial(8'($urandom), 1'b1, 1'b0);
        chk_status("status_par", 1'b1, 1'b0);
        chk_data_read("par_byte_kept");
        wr_reg(2'd3, 4'hF, 32'h0000_0080);
        m_par = 1'b0;
        chk_status("status_par_clr", 1'b1, 1'b0);
`endif

        // False start: one-clock low glitch
        @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (20) @(posedge clk);
        chk_status("status_false_start", 1'b1, 1'b0);

        // TX FIFO full, then exact drain time of 17 back-to-back frames
        wr_reg(2'd0, 4'hF, {24'd0, 8'($urandom)});
        t0 = cyc;
        for (int i = 0; i < 17; i++) wr_reg(2'd0, 4'hF, {24'd0, 8'($urandom)});
        chk_status("status_tx_full", 1'b0, 1'b1);
        while (cyc < t0 + 17 * NBITS * 5 - 10) @(posedge clk);
        chk_status("tx_busy_near_end", 1'b0, 1'b0);
        while (cyc < t0 + 17 * NBITS * 5 + 10) @(posedge clk);
        chk_status("tx_drained", 1'b1, 1'b0);

        // Reset mid-frame
        wr_reg(2'd0, 4'hF, 32'h0000_0000);
        repeat (8) @(posedge clk);
        #2;
        chk("tx_low_before_rst", {68'd0, uart_tx}, 69'd0);
        rst = 1'b1;
        #1;
        chk("rst_async_tx", {68'd0, uart_tx}, 69'd1);
        chk("rst_async_rcn", rcn_out, 69'd0);
        @(negedge clk);
        rst = 1'b0;
        m_baud = 433;
        chk_status("status_after_rst", 1'b1, 1'b0);
        rd_reg(2'd2, v);
        chk("baud_after_rst", {37'd0, v}, {37'd0, 32'd433});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
